// File: rtl/lcd_char_arbiter.sv
// lcd_char_arbiter
//   Shares one character-draw engine among NUM_REQ text controllers using
//   round-robin arbitration. The winner's operands are latched, held stable
//   for one cycle, then the engine is started with a one-cycle flag. The
//   winner is acknowledged once the engine reports done.
//
//   Optional engine-done watchdog: define LCD_ARB_TIMEOUT_EN. Without it,
//   timeout_err is tied low and WAIT waits for done indefinitely.
//
// Ports
//   sys_clk, sys_rst_n     clock, asynchronous active-low reset
//   init_done              arbitration enabled only while high
//   req/req_ascii/req_x/req_y/req_size   per-requester request and operands
//   ack                    one-cycle completion pulse to the granted requester
//   busy                   high whenever the arbiter is not idle
//   timeout_err            one-cycle pulse on watchdog expiry
//   show_char_done         engine completion pulse
//   show_char_flag         one-cycle engine start pulse
//   ascii_num/start_x/start_y/en_size    latched operands to the engine
//
// state | meaning
// IDLE  | waiting for init_done and a request; latches the winner
// SETUP | operands settling at the engine
// FLAG  | show_char_flag pulse
// WAIT  | waiting for show_char_done (or watchdog expiry)
// ACK   | ack pulse to the winner, advance round-robin pointer

module lcd_char_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   init_done,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_ascii,
  input  logic [9*NUM_REQ-1:0]   req_x,
  input  logic [9*NUM_REQ-1:0]   req_y,
  input  logic [NUM_REQ-1:0]     req_size,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   show_char_done,
  output logic                   show_char_flag,
  output logic [6:0]             ascii_num,
  output logic [8:0]             start_x,
  output logic [8:0]             start_y,
  output logic                   en_size
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("lcd_char_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FLAG, S_WAIT, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [6:0]    ascii_q, ascii_d;
  logic [8:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic          size_q, size_d;

  logic [6:0]    asc_a [NUM_REQ];
  logic [8:0]    x_a   [NUM_REQ];
  logic [8:0]    y_a   [NUM_REQ];

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  int            cand_int;
  logic          wd_expire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      asc_a[i] = req_ascii[7*i +: 7];
      x_a[i]   = req_x[9*i +: 9];
      y_a[i]   = req_y[9*i +: 9];
    end
  end

  // First set request at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    cand     = '0;
    cand_int = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int = int'(ptr_q) + k;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand = IW'(cand_int);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_q, wd_d;

  // Cleared in FLAG so the first WAIT cycle counts from zero.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_FLAG)      wd_d = '0;
    else if (state_q == S_WAIT) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) wd_q <= '0;
    else            wd_q <= wd_d;
  end

  assign wd_expire   = (state_q == S_WAIT) && (wd_q == CW'(TIMEOUT_CYC));
  // done on the expiry cycle wins; an abort suppresses the error too
  assign timeout_err = wd_expire && !show_char_done && init_done;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    grant_d        = grant_q;
    ascii_d        = ascii_q;
    x_d            = x_q;
    y_d            = y_q;
    size_d         = size_q;
    ack            = '0;
    show_char_flag = 1'b0;
    if (!init_done) begin
      // Abort: back to IDLE with engine operands cleared, no ack, pointer kept.
      state_d = S_IDLE;
      ascii_d = '0;
      x_d     = '0;
      y_d     = '0;
      size_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_d = pick;
            ascii_d = asc_a[pick];
            x_d     = x_a[pick];
            y_d     = y_a[pick];
            size_d  = req_size[pick];
            state_d = S_SETUP;
          end
        end
        S_SETUP: state_d = S_FLAG;
        S_FLAG: begin
          show_char_flag = 1'b1;
          state_d        = S_WAIT;
        end
        S_WAIT: begin
          if (show_char_done || wd_expire) state_d = S_ACK;
        end
        S_ACK: begin
          ack[grant_q] = 1'b1;
          ptr_d        = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      ascii_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ascii_q <= ascii_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ascii_num = ascii_q;
  assign start_x   = x_q;
  assign start_y   = y_q;
  assign en_size   = size_q;

endmodule

// File: tb/tb_lcd_char_arbiter.sv
module tb_lcd_char_arbiter;

  localparam int N  = 2;
  localparam int TO = 50;
`ifdef LCD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           sys_clk = 1'b0;
  logic           sys_rst_n = 1'b0;
  logic           init_done = 1'b0;
  logic [N-1:0]   req = '0;
  logic [7*N-1:0] req_ascii = '0;
  logic [9*N-1:0] req_x = '0;
  logic [9*N-1:0] req_y = '0;
  logic [N-1:0]   req_size = '0;
  logic           show_char_done = 1'b0;
  logic [N-1:0]   ack;
  logic           busy, timeout_err, show_char_flag, en_size;
  logic [6:0]     ascii_num;
  logic [8:0]     start_x, start_y;

  int checks = 0;
  int failures = 0;
  int eng_delay = 10;
  bit eng_extra = 1'b0;
  int ack_log[$];

  lcd_char_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .req(req), .req_ascii(req_ascii), .req_x(req_x), .req_y(req_y),
    .req_size(req_size), .ack(ack), .busy(busy), .timeout_err(timeout_err),
    .show_char_done(show_char_done), .show_char_flag(show_char_flag),
    .ascii_num(ascii_num), .start_x(start_x), .start_y(start_y),
    .en_size(en_size)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: a character is either not in service, or in service
  // for m_n cycles since its grant (1 = operands settling, 2 = start pulse,
  // 3.. = waiting on the engine), followed by one acknowledge cycle.
  bit         m_busy, m_acking;
  int         m_n, m_g, m_ptr;
  logic [6:0] m_a;
  logic [8:0] m_x, m_y;
  logic       m_s;

  function automatic int first_req(input int p, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin : mdl
    int w;
    if (!sys_rst_n) begin
      m_busy <= 0; m_acking <= 0; m_n <= 0; m_g <= 0; m_ptr <= 0;
      m_a <= '0; m_x <= '0; m_y <= '0; m_s <= 1'b0;
    end else if (!init_done) begin
      m_busy <= 0; m_acking <= 0;
      m_a <= '0; m_x <= '0; m_y <= '0; m_s <= 1'b0;
    end else if (!m_busy) begin
      w = first_req(m_ptr, req);
      if (w >= 0) begin
        m_busy <= 1; m_n <= 1; m_g <= w;
        m_a <= req_ascii[7*w +: 7];
        m_x <= req_x[9*w +: 9];
        m_y <= req_y[9*w +: 9];
        m_s <= req_size[w];
      end
    end else if (m_acking) begin
      m_busy <= 0; m_acking <= 0; m_ptr <= (m_g + 1) % N;
    end else if (m_n >= 3 && (show_char_done || (TO_EN && (m_n - 3 == TO)))) begin
      m_acking <= 1;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge sys_clk) begin : cmp
    logic [N-1:0] e_ack;
    logic         e_flag, e_terr;
    if (sys_rst_n) begin
      e_ack  = (m_acking && init_done) ? N'(1 << m_g) : '0;
      e_flag = m_busy && !m_acking && (m_n == 2) && init_done;
      e_terr = TO_EN && m_busy && !m_acking && (m_n >= 3) && (m_n - 3 == TO)
               && !show_char_done && init_done;
      chk("busy", 64'(busy), 64'(m_busy));
      chk("ack", 64'(ack), 64'(e_ack));
      chk("show_char_flag", 64'(show_char_flag), 64'(e_flag));
      chk("timeout_err", 64'(timeout_err), 64'(e_terr));
      chk("ascii_num", 64'(ascii_num), 64'(m_a));
      chk("start_x", 64'(start_x), 64'(m_x));
      chk("start_y", 64'(start_y), 64'(m_y));
      chk("en_size", 64'(en_size), 64'(m_s));
    end
  end

  // ---------------- engine responder ----------------
  always begin
    @(negedge sys_clk);
    if (show_char_flag && eng_delay > 0) begin
      repeat (eng_delay) @(posedge sys_clk);
      #1 show_char_done = 1'b1;
      @(posedge sys_clk); #1 show_char_done = 1'b0;
      if (eng_extra) begin
        // stray pulses landing in IDLE and SETUP of the next character
        @(posedge sys_clk); #1 show_char_done = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1 show_char_done = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_acks(input int cnt, input bit drop);
    int got = 0;
    for (int n = 0; n < 2000 && got < cnt; n++) begin
      @(negedge sys_clk);
      if (ack != '0) begin
        chk("ack_onehot", 64'($countones(ack)), 64'd1);
        for (int b = 0; b < N; b++) if (ack[b]) ack_log.push_back(b);
        if (drop) req = req & ~ack;
        got++;
      end
    end
    chk("acks_seen", 64'(got), 64'(cnt));
    if (!drop) req = '0;
  endtask

  // n counts negedges from the first cycle the request is visible (n=1).
  task automatic do_char(input int i, input logic [6:0] a, input logic [8:0] x,
                         input logic [8:0] y, input logic s,
                         input int chg_at, input logic [6:0] chg_val,
                         output int t_flag, output int t_ack, output int t_terr,
                         output logic [25:0] ops_flag, output logic [6:0] asc_ack);
    t_flag = -1; t_ack = -1; t_terr = -1; ops_flag = '0; asc_ack = '0;
    @(posedge sys_clk); #1;
    req_ascii[7*i +: 7] = a;
    req_x[9*i +: 9]     = x;
    req_y[9*i +: 9]     = y;
    req_size[i]         = s;
    req[i]              = 1'b1;
    for (int n = 1; n <= 400 && t_ack < 0; n++) begin
      @(negedge sys_clk);
      if (show_char_flag && t_flag < 0) begin
        t_flag   = n;
        ops_flag = {ascii_num, start_x, start_y, en_size};
      end
      if (timeout_err && t_terr < 0) t_terr = n;
      if (n == chg_at) req_ascii[7*i +: 7] = chg_val;
      if (ack[i]) begin
        t_ack   = n;
        asc_ack = ascii_num;
        req[i]  = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         tf, ta, tt, seen;
    logic [25:0] ops;
    logic [6:0] asc;
    int         exp_rr[4]  = '{0, 1, 0, 1};
    int         exp_ab[2]  = '{1, 0};

    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1; init_done = 1'b1;

    // reset and idle
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      chk("idle_outputs", 64'({ack, busy, show_char_flag, timeout_err,
                               ascii_num, start_x, start_y, en_size}), 64'd0);
    end

    // round-robin with both requests held; stray done pulses outside WAIT
    eng_delay = 10; eng_extra = 1'b1;
    @(posedge sys_clk); #1;
    req_ascii = {7'd69, 7'd82};
    req_x     = {9'd80, 9'd8};
    req_y     = {9'd16, 9'd16};
    req_size  = 2'b11;
    req       = 2'b11;
    ack_log.delete();
    run_acks(4, 1'b0);
    chk("rr_count", 64'(ack_log.size()), 64'd4);
    for (int k = 0; k < ack_log.size() && k < 4; k++)
      chk("rr_order", 64'(ack_log[k]), 64'(exp_rr[k]));
    eng_extra = 1'b0;
    repeat (6) @(posedge sys_clk);

    // single request, engine done 10 cycles after the flag
    do_char(0, 7'd82, 9'd72, 9'd16, 1'b1, 0, 7'd0, tf, ta, tt, ops, asc);
    chk("single_flag_latency", 64'(tf), 64'd3);
    chk("single_ops_at_flag", 64'(ops), 64'({7'd82, 9'd72, 9'd16, 1'b1}));
    chk("single_ack_latency", 64'(ta), 64'd14);

    // operand change during WAIT does not affect the current character
    do_char(0, 7'd82, 9'd8, 9'd16, 1'b1, 6, 7'd69, tf, ta, tt, ops, asc);
    chk("stable_ascii_at_ack", 64'(asc), 64'd82);
    chk("stable_ascii_at_flag", 64'(ops[25:19]), 64'd82);
    do_char(0, 7'd69, 9'd8, 9'd16, 1'b1, 0, 7'd0, tf, ta, tt, ops, asc);
    chk("next_grant_ascii", 64'(ops[25:19]), 64'd69);

    // abort during WAIT, then re-serve with pointer unchanged
    eng_delay = -1;
    @(posedge sys_clk); #1;
    req_ascii[13:7] = 7'd69; req_x[17:9] = 9'd80; req_y[17:9] = 9'd32;
    req_size[1] = 1'b0; req[1] = 1'b1;
    seen = 0;
    for (int n = 0; n < 50 && seen == 0; n++) begin
      @(negedge sys_clk);
      if (show_char_flag) seen = 1;
    end
    chk("abort_flag_seen", 64'(seen), 64'd1);
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1 init_done = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_engine_zero", 64'({ascii_num, start_x, start_y, en_size, show_char_flag}), 64'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge sys_clk);
      chk("abort_no_ack", 64'(ack), 64'd0);
    end
    eng_delay = 4;
    @(posedge sys_clk); #1 req[0] = 1'b1; init_done = 1'b1;
    ack_log.delete();
    run_acks(2, 1'b1);
    chk("abort_reserve_count", 64'(ack_log.size()), 64'd2);
    for (int k = 0; k < ack_log.size() && k < 2; k++)
      chk("abort_reserve_order", 64'(ack_log[k]), 64'(exp_ab[k]));
    repeat (3) @(posedge sys_clk);

    // engine never returns done
    eng_delay = -1;
    do_char(0, 7'd49, 9'd0, 9'd0, 1'b0, 0, 7'd0, tf, ta, tt, ops, asc);
    chk("hang_flag_latency", 64'(tf), 64'd3);
`ifdef LCD_ARB_TIMEOUT_EN
    chk("timeout_err_cycle", 64'(tt), 64'd54);
    chk("timeout_ack_cycle", 64'(ta), 64'd55);
    eng_delay = 3;
    do_char(1, 7'd50, 9'd16, 9'd0, 1'b1, 0, 7'd0, tf, ta, tt, ops, asc);
    chk("resume_ack_latency", 64'(ta), 64'd7);
`else
    chk("hang_no_ack", 64'(ta), 64'(-1));
    chk("hang_no_timeout", 64'(tt), 64'(-1));
    chk("hang_busy", 64'(busy), 64'd1);
    @(posedge sys_clk); #1 init_done = 1'b0; req = '0;
    repeat (2) @(posedge sys_clk);
    #1 init_done = 1'b1;
    @(negedge sys_clk);
    chk("hang_recovered_idle", 64'(busy), 64'd0);
`endif

    repeat (3) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
